song_recorder: RTL

//  Record side of the keyboard's song path. Captures the player's 7-key performance as a sequence of {note, duration} entries.

---
 rtl/song_recorder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/song_recorder.sv
// song_recorder: captures a 7-key performance as {note, duration} entries
// in an internal buffer, read back through a registered one-cycle port.
module song_recorder #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int DEPTH       = 64,
    parameter int DUR_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               key_in,
    input  logic                     rec_start,
    input  logic                     rec_stop,
    output logic                     recording,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   song_len,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [2:0]               rd_note,
    output logic [DUR_W-1:0]         rd_dur
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, RECORD} state_t;

    state_t             state, state_n;
    logic [6:0]         key_s1, key_s2;
    logic [2:0]         note, cur_note, cur_note_n;
    logic [DUR_W-1:0]   dur, dur_n, dur_eff;
    logic [TW-1:0]      tick, tick_n;
    logic [AW:0]        song_len_n;
    logic               full_n, wr_en, tick_wrap;
    logic [DUR_W+2:0]   mem [DEPTH];

    always_comb begin
        note = 3'd0;
        for (int i = 6; i >= 0; i--)
            if (key_s2[i]) note = 3'(i + 1);
    end

    // a tick completing on this edge counts toward the segment being closed
    assign tick_wrap = tick == TW'(TICK_CYCLES - 1);
    assign dur_eff   = dur + DUR_W'(tick_wrap);
    assign recording = state == ARMED || state == RECORD;

    always_comb begin
        state_n    = state;
        cur_note_n = cur_note;
        dur_n      = dur;
        tick_n     = tick;
        song_len_n = song_len;
        full_n     = full;
        wr_en      = 1'b0;
        case (state)
            IDLE: if (rec_start) begin
                state_n    = ARMED;
                song_len_n = '0;
                full_n     = 1'b0;
            end
            ARMED: if (rec_stop) begin
                state_n = IDLE;
            end else if (note != 3'd0) begin
                state_n    = RECORD;
                cur_note_n = note;
                dur_n      = '0;
                tick_n     = '0;
            end
            RECORD: begin
                tick_n = tick_wrap ? '0 : tick + TW'(1);
                dur_n  = dur_eff;
                if (rec_stop) begin
                    wr_en   = dur_eff != '0 && cur_note != 3'd0;
                    state_n = IDLE;
                end else if (note != cur_note) begin
                    wr_en      = dur_eff != '0;
                    cur_note_n = note;
                    dur_n      = '0;
                    tick_n     = '0;
                end else if (dur_eff == '1) begin
                    wr_en = 1'b1;
                    dur_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (wr_en) begin
            song_len_n = song_len + (AW + 1)'(1);
            if (song_len_n == (AW + 1)'(DEPTH)) begin
                full_n  = 1'b1;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            key_s1   <= '0;
            key_s2   <= '0;
            cur_note <= '0;
            dur      <= '0;
            tick     <= '0;
            song_len <= '0;
            full     <= 1'b0;
            rd_note  <= '0;
            rd_dur   <= '0;
        end else begin
            state    <= state_n;
            key_s1   <= key_in;
            key_s2   <= key_s1;
            cur_note <= cur_note_n;
            dur      <= dur_n;
            tick     <= tick_n;
            song_len <= song_len_n;
            full     <= full_n;
            {rd_note, rd_dur} <= mem[rd_addr];
        end
    end

    // write pointer is the low bits of the committed count
    always_ff @(posedge clk)
        if (wr_en) mem[song_len[AW-1:0]] <= {cur_note, dur_eff};
endmodule
